// File: rtl/delta_2nd_defs.sv
// +----------------------------------------------------------------------------+
// | delta_2nd_defs : shared state encodings, dimensions and address map        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package delta_2nd_defs;

    localparam int NUM_CEP_DEFAULT   = 13;
    localparam int NUM_FRAME_DEFAULT = 98;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Result memory is laid out frame-major: one row of NUM_CEP words per frame.
    function automatic int unsigned mem_addr(input int unsigned frame,
                                             input int unsigned cep,
                                             input int unsigned num_cep);
        return frame * num_cep + cep;
    endfunction

endpackage

`default_nettype wire

// File: rtl/delta_2nd_frame_cep_counter.sv
// +----------------------------------------------------------------------------+
// | delta_2nd_frame_cep_counter : cep / frame / linear-address counters        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module delta_2nd_frame_cep_counter
    import delta_2nd_defs::*;
#(
    parameter int NUM_CEP    = NUM_CEP_DEFAULT,
    parameter int NUM_FRAME  = NUM_FRAME_DEFAULT,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  cep_over,
    output logic                  frame_over
);

    localparam int CEP_W   = (NUM_CEP > 1)   ? $clog2(NUM_CEP)   : 1;
    localparam int FRAME_W = (NUM_FRAME > 1) ? $clog2(NUM_FRAME) : 1;

    localparam logic [CEP_W-1:0]   C_CEP_MAX   = CEP_W'(NUM_CEP - 1);
    localparam logic [FRAME_W-1:0] C_FRAME_MAX = FRAME_W'(NUM_FRAME - 1);

    logic [CEP_W-1:0]      r_cep;
    logic [FRAME_W-1:0]    r_frame;
    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cep   <= '0;
            r_frame <= '0;
            r_addr  <= '0;
        end else if (clr) begin
            r_cep   <= '0;
            r_frame <= '0;
            r_addr  <= '0;
        end else if (inc) begin
            // The address advances linearly because the map is frame-major.
            r_addr <= r_addr + 1'b1;
            if (cep_over) begin
                r_cep   <= '0;
                r_frame <= frame_over ? '0 : r_frame + 1'b1;
            end else begin
                r_cep <= r_cep + 1'b1;
            end
        end
    end

    assign addr       = r_addr;
    assign cep_over   = (r_cep == C_CEP_MAX);
    assign frame_over = (r_frame == C_FRAME_MAX);

endmodule

`default_nettype wire

// File: rtl/delta_2nd_readout.sv
// +----------------------------------------------------------------------------+
// | delta_2nd_readout : streams delta-delta coefficients out of result memory  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module delta_2nd_readout
    import delta_2nd_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CEP    = NUM_CEP_DEFAULT,
    parameter int NUM_FRAME  = NUM_FRAME_DEFAULT,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  readout_start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last_cep,
    output logic                  out_last_frame,
    output logic                  busy,
    output logic                  done
);

    state_t r_state;
    state_t w_next;

    logic w_clr;
    logic w_inc;
    logic w_cep_over;
    logic w_frame_over;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last_cep;
    logic                  r_last_frame;

    delta_2nd_frame_cep_counter #(
        .NUM_CEP    (NUM_CEP),
        .NUM_FRAME  (NUM_FRAME),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_clr),
        .inc        (w_inc),
        .addr       (rd_addr),
        .cep_over   (w_cep_over),
        .frame_over (w_frame_over)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (readout_start) begin
                    w_clr  = 1'b1;
                    w_next = ST_READ;
                end
            end
            ST_READ:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_SEND;
            ST_SEND: begin
                if (out_ready) begin
                    if (w_cep_over && w_frame_over) begin
                        w_clr  = 1'b1;
                        w_next = ST_DONE;
                    end else begin
                        w_inc  = 1'b1;
                        w_next = ST_READ;
                    end
                end
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // The counters still point at the word being fetched while in CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_last_cep   <= 1'b0;
            r_last_frame <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_data       <= rd_data;
            r_last_cep   <= w_cep_over;
            r_last_frame <= w_frame_over;
        end
    end

    assign rd_en          = (r_state == ST_READ);
    assign out_valid      = (r_state == ST_SEND);
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign out_data       = r_data;
    assign out_last_cep   = r_last_cep;
    assign out_last_frame = r_last_frame;

endmodule

`default_nettype wire

// File: tb/tb_delta_2nd_readout.sv
// +----------------------------------------------------------------------------+
// | tb_delta_2nd_readout : randomized self-checking bench for delta_2nd_readout|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_delta_2nd_readout;

    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int NC0 = 13;
    localparam int NF0 = 3;
    localparam int NC1 = 1;
    localparam int NF1 = 1;
    localparam int MEM_DEPTH = NC0 * NF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic readout_start;
    logic out_ready;
    logic sel;

    logic          rd_en0, rd_en1;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          out_valid0, out_valid1;
    logic [DW-1:0] out_data0, out_data1;
    logic          lc0, lc1, lf0, lf1;
    logic          busy0, busy1, done0, done1;

    logic [DW-1:0] mem [0:MEM_DEPTH-1];

    int compared   = 0;
    int mismatched = 0;

    delta_2nd_readout #(.DATA_WIDTH(DW), .NUM_CEP(NC0), .NUM_FRAME(NF0), .ADDR_WIDTH(AW)) dut0 (
        .clk(clk), .rst_n(rst_n), .readout_start(readout_start),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_last_cep(lc0), .out_last_frame(lf0), .busy(busy0), .done(done0)
    );

    delta_2nd_readout #(.DATA_WIDTH(DW), .NUM_CEP(NC1), .NUM_FRAME(NF1), .ADDR_WIDTH(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .readout_start(readout_start),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_last_cep(lc1), .out_last_frame(lf1), .busy(busy1), .done(done1)
    );

    // Synchronous-read result memory shared by both instances.
    always @(posedge clk) begin
        if (rd_en0 && rd_addr0 < AW'(MEM_DEPTH)) rd_data0 <= mem[rd_addr0];
        if (rd_en1 && rd_addr1 < AW'(MEM_DEPTH)) rd_data1 <= mem[rd_addr1];
    end

    wire          s_rd_en = sel ? rd_en1     : rd_en0;
    wire [AW-1:0] s_addr  = sel ? rd_addr1   : rd_addr0;
    wire          s_valid = sel ? out_valid1 : out_valid0;
    wire [DW-1:0] s_data  = sel ? out_data1  : out_data0;
    wire          s_lc    = sel ? lc1        : lc0;
    wire          s_lf    = sel ? lf1        : lf0;
    wire          s_busy  = sel ? busy1      : busy0;
    wire          s_done  = sel ? done1      : done0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {15'd0, rd_en0, rd_addr0, out_valid0, out_data0, lc0, lf0, busy0, done0}, 64'd0);
        chk(tag, {15'd0, rd_en1, rd_addr1, out_valid1, out_data1, lc1, lf1, busy1, done1}, 64'd0);
    endtask

    // One readout pass checked against a word-sequence model: word w lives at
    // frame w/nc, cep w%nc; each word needs 3 cycles plus any refused SEND cycles.
    task automatic run_pass(input int nc, input int nf, input bit rand_ready,
                            input int mid_start_at, input int abort_word);
        int  n, words, next_valid, last_acc, f, c;
        bit  hold, done_seen, nr, exp_valid;
        logic [DW-1:0] held;
        n = nc * nf; words = 0; next_valid = 3; last_acc = -10;
        hold = 1'b0; done_seen = 1'b0; held = '0;
        @(negedge clk);
        readout_start = 1'b1;
        out_ready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 1; i <= 20 * n + 20; i++) begin
            @(negedge clk);
            readout_start = (i == mid_start_at);
            exp_valid = (words < n) && (i >= next_valid);
            chk("out_valid", s_valid, exp_valid);
            chk("busy", s_busy, 1'b1);
            chk("done", s_done, (words == n) && (i == last_acc + 1));
            chk("rd_en", s_rd_en, (words < n) && (i == next_valid - 2));
            if (s_rd_en) chk("rd_addr", s_addr, words);
            if (hold) chk("hold_data", s_data, held);
            if (s_done) begin
                done_seen = 1'b1;
                break;
            end
            if (s_valid && words == abort_word) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("abort_zero");
                return;
            end
            nr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = nr;
            hold = 1'b0;
            if (s_valid && nr) begin
                f = words / nc;
                c = words % nc;
                chk("out_data", s_data, mem[f * nc + c]);
                chk("last_cep", s_lc, (c == nc - 1));
                chk("last_frame", s_lf, (f == nf - 1));
                words++;
                last_acc   = i;
                next_valid = i + 3;
            end else if (s_valid) begin
                hold = 1'b1;
                held = s_data;
            end
        end
        readout_start = 1'b0;
        chk("done_seen", done_seen, 1'b1);
        chk("word_count", words, n);
    endtask

    initial begin
        rst_n = 1'b0; readout_start = 1'b0; out_ready = 1'b0; sel = 1'b0;
        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = DW'(a + 100);
        repeat (3) @(negedge clk);
        chk_all_zero("reset_zero");
        rst_n = 1'b1;

        run_pass(NC0, NF0, 1'b0, -1, -1);
        run_pass(NC0, NF0, 1'b1, -1, -1);
        run_pass(NC0, NF0, 1'b0, 9, -1);

        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = $urandom;
        run_pass(NC0, NF0, 1'b1, -1, -1);
        run_pass(NC0, NF0, 1'b1, -1, 5);
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(NC0, NF0, 1'b1, -1, -1);

        repeat (3) @(negedge clk);
        sel = 1'b1;
        run_pass(NC1, NF1, 1'b0, -1, -1);
        run_pass(NC1, NF1, 1'b1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
